// File: rtl/sprite_linebuf.sv
// Dual-bank ping-pong sprite line buffer: priority-resolving pixel writes into
// one bank while the other bank is streamed out in scan order and cleared.
module sprite_linebuf #(
   parameter int XW         = 8,
   parameter bit FIRST_WINS = 1'b1
) (
   input  logic          CK1,
   input  logic          RESET,
   input  logic          CEN,
   input  logic          LINE_START,
   input  logic          WR_EN,
   input  logic [XW-1:0] WR_X,
   input  logic [3:0]    WR_COL,
   input  logic [3:0]    WR_PAL,
   input  logic          RD_EN,
   output logic [3:0]    PIX_COL,
   output logic [3:0]    PIX_PAL,
   output logic          PIX_OPAQUE,
   output logic          PIX_STB,
   output logic          BANK
);

   localparam int DEPTH = 1 << XW;
   localparam int AW    = XW + 1;

   typedef struct packed {
      logic          bank;
      logic [XW-1:0] x;
      logic [3:0]    pal;
      logic [3:0]    col;
   } wr_req_t;

   logic             bank_q,    bank_d;
   logic [XW-1:0]    rd_x_q,    rd_x_d;
   logic             wr_vld_q,  wr_vld_d;
   wr_req_t          wr_req_q,  wr_req_d;
   logic             wr_hit_q,  wr_hit_d;
   logic [2*DEPTH-1:0] valid_q, valid_d;
   logic [3:0]       pix_col_q, pix_col_d;
   logic [3:0]       pix_pal_q, pix_pal_d;
   logic             pix_opq_q, pix_opq_d;
   logic             pix_stb_q, pix_stb_d;

   logic [7:0]       mem [2*DEPTH];
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [7:0]       mem_wdata;

   logic [AW-1:0]    s1_addr;
   logic [AW-1:0]    s2_addr;
   logic             s2_write;
   logic             s1_hit;
   logic [AW-1:0]    rd_addr;
   logic             rd_valid;
   logic [7:0]       rd_data;
   logic             rd_fire;

   // S2 decides from the occupancy seen in S1; an S2 write to the address S1 is
   // probing right now is forwarded so back-to-back hits resolve correctly.
   assign s1_addr  = {bank_q, WR_X};
   assign s2_addr  = {wr_req_q.bank, wr_req_q.x};
   assign s2_write = wr_vld_q && (wr_req_q.col != 4'd0) && (!FIRST_WINS || !wr_hit_q);
   assign s1_hit   = valid_q[s1_addr] | (s2_write && (s2_addr == s1_addr));

   assign rd_addr  = {~bank_q, rd_x_q};
   assign rd_valid = valid_q[rd_addr];
   assign rd_data  = mem[rd_addr];
   assign rd_fire  = RD_EN && !LINE_START;

   assign mem_waddr = s2_addr;
   assign mem_wdata = {wr_req_q.pal, wr_req_q.col};

   always_comb begin
      bank_d    = bank_q;
      rd_x_d    = rd_x_q;
      wr_vld_d  = wr_vld_q;
      wr_req_d  = wr_req_q;
      wr_hit_d  = wr_hit_q;
      valid_d   = valid_q;
      pix_col_d = pix_col_q;
      pix_pal_d = pix_pal_q;
      pix_opq_d = pix_opq_q;
      pix_stb_d = pix_stb_q;
      mem_we    = 1'b0;

      if (CEN) begin
         wr_vld_d  = WR_EN;
         wr_req_d  = '{bank: bank_q, x: WR_X, pal: WR_PAL, col: WR_COL};
         wr_hit_d  = s1_hit;
         pix_stb_d = rd_fire;

         if (rd_fire) begin
            pix_col_d        = rd_valid ? rd_data[3:0] : 4'd0;
            pix_pal_d        = rd_valid ? rd_data[7:4] : 4'd0;
            pix_opq_d        = rd_valid;
            valid_d[rd_addr] = 1'b0;
            rd_x_d           = rd_x_q + 1'b1;
         end

         // Applied after the read clear so a completing write is never lost.
         if (s2_write) begin
            valid_d[s2_addr] = 1'b1;
            mem_we           = 1'b1;
         end

         if (LINE_START) begin
            bank_d = ~bank_q;
            rd_x_d = '0;
         end
      end
   end

   always_ff @(posedge CK1) begin
      if (RESET) begin
         bank_q    <= 1'b0;
         rd_x_q    <= '0;
         wr_vld_q  <= 1'b0;
         wr_req_q  <= '0;
         wr_hit_q  <= 1'b0;
         valid_q   <= '0;
         pix_col_q <= 4'd0;
         pix_pal_q <= 4'd0;
         pix_opq_q <= 1'b0;
         pix_stb_q <= 1'b0;
      end else begin
         bank_q    <= bank_d;
         rd_x_q    <= rd_x_d;
         wr_vld_q  <= wr_vld_d;
         wr_req_q  <= wr_req_d;
         wr_hit_q  <= wr_hit_d;
         valid_q   <= valid_d;
         pix_col_q <= pix_col_d;
         pix_pal_q <= pix_pal_d;
         pix_opq_q <= pix_opq_d;
         pix_stb_q <= pix_stb_d;
      end
   end

   // NOTE: pixel storage has no reset; the valid flops alone define emptiness.
   always_ff @(posedge CK1) begin
      if (mem_we && !RESET) mem[mem_waddr] <= mem_wdata;
   end

   assign PIX_COL    = pix_col_q;
   assign PIX_PAL    = pix_pal_q;
   assign PIX_OPAQUE = pix_opq_q;
   assign PIX_STB    = pix_stb_q;
   assign BANK       = bank_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Scoreboard bench for sprite_linebuf: one instance per priority mode, both fed
// the same stimulus and checked against a behavioural line-buffer model.
module tb_sprite_linebuf;

   logic       clk = 1'b0;
   logic       RESET, CEN, LINE_START, WR_EN, RD_EN;
   logic [7:0] WR_X;
   logic [3:0] WR_COL, WR_PAL;

   logic [3:0] col1, pal1, col0, pal0;
   logic       opq1, stb1, bank1, opq0, stb0, bank0;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0] c1, p1, c0, p0;
      logic       o1, o0;
   } exp_t;
   exp_t sb[$];

   // Model state indexed [first_wins][bank][x].
   bit         mv [2][2][256];
   logic [3:0] mc [2][2][256];
   logic [3:0] mp [2][2][256];
   bit         m_bank;
   logic [7:0] m_rdx;

   always #5 clk = ~clk;

   sprite_linebuf #(.XW(8), .FIRST_WINS(1'b1)) dut_fw1 (
      .CK1(clk), .RESET(RESET), .CEN(CEN), .LINE_START(LINE_START),
      .WR_EN(WR_EN), .WR_X(WR_X), .WR_COL(WR_COL), .WR_PAL(WR_PAL),
      .RD_EN(RD_EN), .PIX_COL(col1), .PIX_PAL(pal1), .PIX_OPAQUE(opq1),
      .PIX_STB(stb1), .BANK(bank1)
   );

   sprite_linebuf #(.XW(8), .FIRST_WINS(1'b0)) dut_fw0 (
      .CK1(clk), .RESET(RESET), .CEN(CEN), .LINE_START(LINE_START),
      .WR_EN(WR_EN), .WR_X(WR_X), .WR_COL(WR_COL), .WR_PAL(WR_PAL),
      .RD_EN(RD_EN), .PIX_COL(col0), .PIX_PAL(pal0), .PIX_OPAQUE(opq0),
      .PIX_STB(stb0), .BANK(bank0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (stb1 === 1'b1 || stb0 === 1'b1) begin
         if (sb.size() == 0) begin
            check("stray_stb", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("stb_fw1", stb1, 1);
            check("stb_fw0", stb0, 1);
            check("col_fw1", col1, e.c1);
            check("pal_fw1", pal1, e.p1);
            check("opq_fw1", opq1, e.o1);
            check("col_fw0", col0, e.c0);
            check("pal_fw0", pal0, e.p0);
            check("opq_fw0", opq0, e.o0);
         end
      end
   end

   task automatic drive(input bit rst, input bit cen, input bit ls, input bit we,
                        input logic [7:0] x, input logic [3:0] col, input logic [3:0] pal,
                        input bit re);
      exp_t e;
      int   b;
      RESET = rst; CEN = cen; LINE_START = ls; WR_EN = we;
      WR_X = x; WR_COL = col; WR_PAL = pal; RD_EN = re;
      if (rst) begin
         for (int v = 0; v < 2; v++)
            for (int bb = 0; bb < 2; bb++)
               for (int i = 0; i < 256; i++) mv[v][bb][i] = 1'b0;
         m_bank = 1'b0;
         m_rdx  = 8'd0;
      end else if (cen) begin
         if (re && !ls) begin
            b    = m_bank ? 0 : 1;
            e.o1 = mv[1][b][m_rdx];
            e.c1 = e.o1 ? mc[1][b][m_rdx] : 4'd0;
            e.p1 = e.o1 ? mp[1][b][m_rdx] : 4'd0;
            e.o0 = mv[0][b][m_rdx];
            e.c0 = e.o0 ? mc[0][b][m_rdx] : 4'd0;
            e.p0 = e.o0 ? mp[0][b][m_rdx] : 4'd0;
            mv[1][b][m_rdx] = 1'b0;
            mv[0][b][m_rdx] = 1'b0;
            sb.push_back(e);
            m_rdx = m_rdx + 8'd1;
         end
         if (we && col != 4'd0) begin
            for (int v = 0; v < 2; v++) begin
               if (v == 0 || !mv[v][m_bank][x]) begin
                  mv[v][m_bank][x] = 1'b1;
                  mc[v][m_bank][x] = col;
                  mp[v][m_bank][x] = pal;
               end
            end
         end
         if (ls) begin
            m_bank = !m_bank;
            m_rdx  = 8'd0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 8'd0, 4'd0, 4'd0, 0);
   endtask

   task automatic rd(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 8'd0, 4'd0, 4'd0, 1);
   endtask

   task automatic wr(input logic [7:0] x, input logic [3:0] col, input logic [3:0] pal);
      drive(0, 1, 0, 1, x, col, pal, 0);
   endtask

   task automatic lstart();
      drive(0, 1, 1, 0, 8'd0, 4'd0, 4'd0, 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_bank1"}, bank1, 0);
      check({tag, "_bank0"}, bank0, 0);
      check({tag, "_stb"},   stb1,  0);
      check({tag, "_col"},   col1,  0);
      check({tag, "_pal"},   pal1,  0);
      check({tag, "_opq"},   opq1,  0);
   endtask

   task automatic drain(input string tag);
      idle(2);
      check(tag, sb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      RESET = 1'b1; CEN = 1'b0; LINE_START = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0;
      WR_X = '0; WR_COL = '0; WR_PAL = '0;
      m_bank = 1'b0; m_rdx = 8'd0;

      // Reset, swap, and stream an empty line.
      drive(1, 1, 0, 0, 8'd0, 4'd0, 4'd0, 0);
      check_reset_state("reset");
      lstart();
      check("bank_after_ls", bank1, 1);
      rd(256);
      drain("drain_empty_line");

      // Single pixel at X=10, hold behaviour, then cleared-on-read pass with wrap.
      lstart();
      check("bank_write0", bank1, 0);
      wr(8'd10, 4'd5, 4'd3);
      lstart();
      rd(11);
      idle(1);
      check("hold_stb", stb1, 0);
      check("hold_col", col1, 5);
      check("hold_pal", pal1, 3);
      check("hold_opq", opq1, 1);
      lstart();
      lstart();
      rd(257);
      drain("drain_cleared");

      // Priority: back-to-back same-X writes, and a transparent overwrite.
      wr(8'd20, 4'd7, 4'd1);
      wr(8'd20, 4'd2, 4'd2);
      wr(8'd30, 4'd4, 4'd5);
      idle(1);
      wr(8'd30, 4'd0, 4'd9);
      idle(1);
      lstart();
      rd(31);
      drain("drain_priority");

      // Write coincident with LINE_START lands in the bank about to be read.
      drive(0, 1, 1, 1, 8'd40, 4'd1, 4'd6, 0);
      wr(8'd0, 4'd9, 4'd8);
      rd(41);
      // LINE_START beats RD_EN; the next read must start again at X=0.
      drive(0, 1, 1, 0, 8'd0, 4'd0, 4'd0, 1);
      check("ls_rd_no_stb", stb1, 0);
      check("ls_rd_bank", bank1, 0);
      rd(1);
      drain("drain_ls_wr");

      // Clock-enable low freezes read X and ignores all strobes.
      wr(8'd5, 4'hA, 4'hB);
      wr(8'd6, 4'hC, 4'hD);
      lstart();
      rd(3);
      idle(1);
      drive(0, 0, 1, 1, 8'd3, 4'hF, 4'hF, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'd0, 4'd0, 4'd0, 1);
      check("cen_bank", bank1, 1);
      check("cen_no_stb", stb1, 0);
      rd(4);
      drain("drain_cen");

      // Reset while a write sits in S2: nothing may land.
      wr(8'd50, 4'd3, 4'd4);
      drive(1, 1, 0, 0, 8'd0, 4'd0, 4'd0, 0);
      check_reset_state("midreset");
      lstart();
      lstart();
      rd(256);
      drain("drain_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
